// File: rtl/reg_xfer_ctl.sv
// rtl/reg_xfer_ctl.sv - register-file transfer sequencer (read/write/copy/swap)
module reg_xfer_ctl #(
    parameter int         TURN     = 1,
    parameter logic [3:0] TMP_CODE = 4'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [3:0]  src,
    input  logic [3:0]  dst,
    input  logic [1:0]  byte_en,
    output logic [13:0] reg_sel,
    output logic        reg_sel_gp_hi,
    output logic        reg_sel_gp_lo,
    output logic        reg_gp_oe,
    output logic        reg_gp_we,
    output logic        reg_sel_sys_hi,
    output logic        reg_sel_sys_lo,
    output logic        reg_sys_oe,
    output logic        reg_sys_we_hi,
    output logic        reg_sys_we_lo,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SWAP  = 2'd3;
    localparam logic [1:0] TURN_W   = 2'(TURN);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_TA, S_WR, S_DONE} state_t;

    typedef struct packed {
        logic [13:0] sel;
        logic        gp_hi;
        logic        gp_lo;
        logic        gp_oe;
        logic        gp_we;
        logic        sys_hi;
        logic        sys_lo;
        logic        sys_oe;
        logic        sys_we_hi;
        logic        sys_we_lo;
    } strobe_t;

    state_t     state;
    strobe_t    so;
    logic [1:0] op_q;
    logic [3:0] src_q;
    logic [3:0] dst_q;
    logic [1:0] be_q;
    logic [1:0] phase;
    logic [1:0] phase_nxt;
    logic [1:0] ta_cnt;

    assign phase_nxt = phase + 2'd1;

    function automatic strobe_t step_out(input logic wr, input logic [3:0] code,
                                         input logic [1:0] be);
        strobe_t s;
        s     = '0;
        s.sel = 14'(1) << code;
        if (code < 4'd12) begin
            s.gp_hi = be[1];
            s.gp_lo = be[0];
            s.gp_oe = ~wr;
            s.gp_we = wr;
        end else if (wr) begin
            s.sys_we_hi = be[1];
            s.sys_we_lo = be[0];
        end else begin
            s.sys_hi = be[1];
            s.sys_lo = be[0];
            s.sys_oe = 1'b1;
        end
        return s;
    endfunction

    // Swap runs three RD/WR phases through the temporary: src->tmp, dst->src, tmp->dst
    function automatic logic [3:0] rd_code(input logic [1:0] o, input logic [1:0] p,
                                           input logic [3:0] s, input logic [3:0] d);
        if (o != OP_SWAP || p == 2'd0) return s;
        else if (p == 2'd1)            return d;
        else                           return TMP_CODE;
    endfunction

    function automatic logic [3:0] wr_code(input logic [1:0] o, input logic [1:0] p,
                                           input logic [3:0] s, input logic [3:0] d);
        if (o != OP_SWAP || p == 2'd2) return d;
        else if (p == 2'd1)            return s;
        else                           return TMP_CODE;
    endfunction

    function automatic logic illegal(input logic [1:0] o, input logic [3:0] s,
                                     input logic [3:0] d, input logic [1:0] be);
        logic bad;
        bad = (be == 2'b00);
        if (o != OP_WRITE && s > 4'd13) bad = 1'b1;
        if (o != OP_READ  && d > 4'd13) bad = 1'b1;
        if (o == OP_SWAP && (s == TMP_CODE || d == TMP_CODE || s == d)) bad = 1'b1;
        return bad;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            so     <= '0;
            op_q   <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            be_q   <= '0;
            phase  <= '0;
            ta_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    so    <= '0;
                    if (req) begin
                        if (illegal(op, src, dst, byte_en)) begin
                            err <= 1'b1;
                        end else begin
                            op_q   <= op;
                            src_q  <= src;
                            dst_q  <= dst;
                            be_q   <= byte_en;
                            phase  <= 2'd0;
                            ta_cnt <= 2'd0;
                            busy   <= 1'b1;
                            if (op == OP_WRITE) begin
                                state <= S_WR;
                                so    <= step_out(1'b1, dst, byte_en);
                            end else begin
                                state <= S_RD;
                                so    <= step_out(1'b0, src, byte_en);
                            end
                        end
                    end
                end
                S_RD: begin
                    if (op_q == OP_READ) begin
                        state <= S_DONE;
                        so    <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (TURN == 0) begin
                        state <= S_WR;
                        so    <= step_out(1'b1, wr_code(op_q, phase, src_q, dst_q), be_q);
                    end else begin
                        state  <= S_TA;
                        so     <= '0;
                        ta_cnt <= 2'd1;
                    end
                end
                S_TA: begin
                    if (ta_cnt == TURN_W) begin
                        state <= S_WR;
                        so    <= step_out(1'b1, wr_code(op_q, phase, src_q, dst_q), be_q);
                    end else begin
                        ta_cnt <= ta_cnt + 2'd1;
                    end
                end
                S_WR: begin
                    if (op_q == OP_SWAP && phase != 2'd2) begin
                        state <= S_RD;
                        phase <= phase_nxt;
                        so    <= step_out(1'b0, rd_code(op_q, phase_nxt, src_q, dst_q), be_q);
                    end else begin
                        state <= S_DONE;
                        so    <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    so    <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_sel        = so.sel;
    assign reg_sel_gp_hi  = so.gp_hi;
    assign reg_sel_gp_lo  = so.gp_lo;
    assign reg_gp_oe      = so.gp_oe;
    assign reg_gp_we      = so.gp_we;
    assign reg_sel_sys_hi = so.sys_hi;
    assign reg_sel_sys_lo = so.sys_lo;
    assign reg_sys_oe     = so.sys_oe;
    assign reg_sys_we_hi  = so.sys_we_hi;
    assign reg_sys_we_lo  = so.sys_we_lo;

endmodule

// File: doc/reg_xfer_ctl.md
Name: reg_xfer_ctl

Overview:
Register control sequencer that drives the register file's select, output-enable and write-enable strobes. It turns one requested transfer (read, write, copy or swap of a register pair) into a timed sequence of T-cycle bus steps. It sits between the instruction decoder and the register file and owns all reg_sel_*, *_oe and *_we control lines. It does not touch the data buses.

Parameters:
TURN, 1, idle bus-turnaround cycles inserted after every read step (0..3)
TMP_CODE, 10, register code used as the swap temporary (10 = WZ)

Ports:
clk  input  1  T-clock, rising edge
reset  input  1  asynchronous, active-high
req  input  1  start pulse; sampled only when busy=0
op  input  2  0=READ src, 1=WRITE dst, 2=COPY src->dst, 3=SWAP src<->dst
src  input  4  source code: 0 AF,1 AF2,2 BC,3 BC2,4 DE,5 DE2,6 HL,7 HL2,8 IX,9 IY,10 WZ,11 SP,12 PC,13 IR; 14,15 illegal
dst  input  4  destination code, same encoding
byte_en  input  2  [1]=high byte, [0]=low byte
reg_sel  output  14  one-hot register select, bit index = code
reg_sel_gp_hi, reg_sel_gp_lo  output  1  GP byte selects
reg_gp_oe, reg_gp_we  output  1  GP read/write strobes
reg_sel_sys_hi, reg_sel_sys_lo  output  1  system (PC/IR) byte selects
reg_sys_oe  output  1  system read strobe
reg_sys_we_hi, reg_sys_we_lo  output  1  system byte write strobes
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (async, any time, including mid-sequence): all outputs 0, FSM to IDLE, latched request cleared.
- Outputs are registered. All strobes and selects are 0 outside a step.
- States: IDLE, RD, TA, WR, DONE. A step counter of 0..2 tracks swap phases.
- Acceptance: in IDLE, or in the DONE cycle, req=1 latches op/src/dst/byte_en. Later input changes are ignored until the next acceptance. req while busy=1 is ignored, with no err.
- Rejection: codes 14/15 used by op, byte_en=0, or SWAP with src or dst equal to TMP_CODE, or src==dst. Result: err=1 on the following cycle, busy stays 0, no strobes.
- RD step (1 cycle): reg_sel[code]=1. Codes 0..11 give gp_hi/lo = byte_en and reg_gp_oe=1. Codes 12,13 give sys_hi/lo = byte_en and reg_sys_oe=1.
- TA: TURN cycles, everything 0. Skipped when TURN=0.
- WR step (1 cycle): reg_sel[code]=1. Codes 0..11 give gp byte selects = byte_en and reg_gp_we=1. Codes 12,13 give reg_sys_we_hi/lo = byte_en.
- No turnaround after a WR step.
- Sequences (N = active cycles):
  - READ: RD(src); N=1
  - WRITE: WR(dst); N=1
  - COPY: RD(src),TA,WR(dst); N=2+TURN
  - SWAP: RD(src),TA,WR(TMP), RD(dst),TA,WR(src), RD(TMP),TA,WR(dst); N=6+3·TURN
- Timing: req accepted on edge k, first step visible cycle k+1. busy=1 for cycles k+1..k+N. done=1, busy=0 in cycle k+N+1. done and err are never high together.
- Exactly one bit of reg_sel is high during a step. oe and we are never high in the same cycle.

Test Plan:
- Reset mid-SWAP (cycle 4): all outputs 0 immediately, before the next edge. A subsequent READ AF runs normally.
- READ src=6 (HL), byte_en=11: cycle k+1 shows reg_sel=0x0040, gp_hi=gp_lo=1, reg_gp_oe=1, busy=1. Cycle k+2 shows done=1, all strobes 0.
- COPY src=12 (PC) dst=11 (SP), byte_en=01, TURN=1: k+1 sys_lo=1 + reg_sys_oe; k+2 idle; k+3 reg_sel bit11 + gp_lo + reg_gp_we; done at k+4.
- SWAP src=4 dst=6, TURN=1: 9 active cycles, select order DE,-,WZ,HL,-,DE,WZ,-,HL with oe/we alternating. done at k+10. req pulsed at k+5 is ignored.
- Illegal cases, each giving err=1 for one cycle, busy=0, no strobes: src=14 READ; SWAP dst=10; byte_en=00 WRITE.
- Back-to-back: a new req in the done cycle of a READ starts a WRITE with its strobe in the next cycle and no idle gap.
